pc_gen: RTL

//  Parametrised program-counter generator for the pipelined core; successor to the single-cycle PC/next-PC logic.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_gen_ras_stack.sv | 54 +++++
 rtl/pc_gen.sv | 105 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter generator.
//   pc_src_e       identifies which source loaded the current fetch PC
//   PC_ALIGN_MASK  low PC bits that must be zero for an aligned fetch
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_RESET    = 3'd0,
    SRC_SEQ      = 3'd1,
    SRC_JUMP     = 3'd2,
    SRC_RET      = 3'd3,
    SRC_REDIRECT = 3'd4
  } pc_src_e;

  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// ras_stack: circular return-address stack (LIFO).
//   clk, rst   clock and synchronous active-high reset
//   push       write push_data as the new top
//   pop        discard the top entry (ignored when empty)
//   push_data  link address to store
//   top        current top entry (undefined when empty)
//   empty      no valid entries
//   full       DEPTH valid entries
// Push and pop together replace the top in place. A push into a full stack
// overwrites the oldest entry because the pointer simply wraps.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW:0]      count;
  logic [PW-1:0]    top_idx;

  // ptr names the next free slot, so the top sits one below it (mod DEPTH).
  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && pop && !empty) begin
      mem[top_idx] <= push_data;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + PW'(1);
      if (!full) count <= count + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PW'(1);
      count <= count - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator for the pipelined core.
//   clk, rst     clock and synchronous active-high reset
//   stall        hold the PC (hazard unit)
//   redirect     execute-stage redirect to redirect_pc (bit 0 cleared)
//   jump         decode-stage jal to jump_pc
//   call, ret    decode call/return hints; link_pc is the address pushed
//   pc_current   fetch address (registered)
//   pc_src       which source loaded pc_current
//   misalign     pc_current has non-zero low bits
//   ras_empty    return-address stack holds nothing
// Next-PC priority: redirect > stall > jump > return prediction > sequential.
// Define PC_RAS_EN to build the return-address stack; without it call/ret
// are ignored and ras_empty is tied high.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              PC_STEP      = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_pc,
  input  logic            call,
  input  logic [XLEN-1:0] link_pc,
  input  logic            ret,
  output logic [XLEN-1:0] pc_current,
  output pc_src_e         pc_src,
  output logic            misalign,
  output logic            ras_empty
);

  logic [XLEN-1:0] next_pc;
  pc_src_e         next_src;
  logic            load_en;

`ifdef PC_RAS_EN
  logic [XLEN-1:0] ras_top;
  logic            ras_push;
  logic            ras_pop;
  logic            unused_ras_full;

  // Decode-side push/pop are wrong-path work when execute redirects, and
  // must not be repeated while the front end is stalled.
  assign ras_push = call && !redirect && !stall;
  assign ras_pop  = ret  && !redirect && !stall;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (XLEN)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link_pc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (unused_ras_full)
  );
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = ^{call, ret, link_pc, RAS_DEPTH[0]};
  assign ras_empty = 1'b1;
`endif

  // A redirect overrides a stall, so the register loads unless stalled alone.
  assign load_en = redirect || !stall;

  always_comb begin
    next_pc  = pc_current + XLEN'(PC_STEP);
    next_src = SRC_SEQ;
    if (redirect) begin
      next_pc  = redirect_pc & ~XLEN'(1);
      next_src = SRC_REDIRECT;
    end else if (jump) begin
      next_pc  = jump_pc;
      next_src = SRC_JUMP;
`ifdef PC_RAS_EN
    end else if (ret && !ras_empty) begin
      next_pc  = ras_top;
      next_src = SRC_RET;
`endif
    end
  end

  // misalign travels with the PC it describes; the trap is taken downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_current <= RESET_VECTOR;
      pc_src     <= SRC_RESET;
      misalign   <= 1'b0;
    end else if (load_en) begin
      pc_current <= next_pc;
      pc_src     <= next_src;
      misalign   <= |(next_pc[1:0] & PC_ALIGN_MASK);
    end
  end

endmodule
